// File: rtl/rr_resource_arbiter.sv
// rr_resource_arbiter: round-robin arbiter granting one shared resource to NUM_REQ requesters with hold timeout
module rr_resource_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int MAX_HOLD = 256,
  localparam int ID_WIDTH = NUM_REQ > 1 ? $clog2(NUM_REQ) : 1
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic [NUM_REQ-1:0]  request,
  input  logic                done,
  output logic [NUM_REQ-1:0]  grant,
  output logic [ID_WIDTH-1:0] grant_id,
  output logic                grant_valid,
  output logic                timeout_error
);
  localparam int HW = $clog2(MAX_HOLD);
  typedef enum logic [1:0] {IDLE, GRANT, GAP} state_t;
  state_t state;
  logic [HW-1:0] hold_cnt;
  logic [ID_WIDTH-1:0] pointer, winner, masked_winner, pick;
  logic masked_any;
  always_comb begin
    winner = '0;
    masked_winner = '0;
    masked_any = 1'b0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (request[i]) winner = ID_WIDTH'(i);
      if (request[i] && i > int'(pointer)) begin
        masked_winner = ID_WIDTH'(i);
        masked_any = 1'b1;
      end
    end
    pick = masked_any ? masked_winner : winner;
  end
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state <= IDLE;
      grant <= '0;
      grant_id <= '0;
      grant_valid <= 1'b0;
      timeout_error <= 1'b0;
      hold_cnt <= '0;
      pointer <= ID_WIDTH'(NUM_REQ - 1);
    end else begin
      case (state)
        IDLE: begin
          timeout_error <= 1'b0;
          if (|request) begin
            grant <= NUM_REQ'(1) << pick;
            grant_id <= pick;
            grant_valid <= 1'b1;
            hold_cnt <= '0;
            state <= GRANT;
          end
        end
        GRANT: begin
          hold_cnt <= hold_cnt + 1'b1;
          if (done || hold_cnt == HW'(MAX_HOLD - 1)) begin
            grant <= '0;
            grant_valid <= 1'b0;
            pointer <= grant_id;
            timeout_error <= !done;
            hold_cnt <= '0;
            state <= GAP;
          end
        end
        default: begin
          timeout_error <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_rr_resource_arbiter.sv
// tb_rr_resource_arbiter: directed self-checking bench for rr_resource_arbiter
module tb_rr_resource_arbiter;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rn, dn, rn5, dn5;
  logic [3:0] req, g;
  logic [4:0] req5, g5;
  logic [1:0] gid;
  logic [2:0] gid5;
  logic gv, te, gv5, te5;
  int checks = 0, errors = 0;
  rr_resource_arbiter #(.NUM_REQ(4), .MAX_HOLD(8)) u4 (
    .clock(clk), .reset_n(rn), .request(req), .done(dn),
    .grant(g), .grant_id(gid), .grant_valid(gv), .timeout_error(te));
  rr_resource_arbiter #(.NUM_REQ(5), .MAX_HOLD(8)) u5 (
    .clock(clk), .reset_n(rn5), .request(req5), .done(dn5),
    .grant(g5), .grant_id(gid5), .grant_valid(gv5), .timeout_error(te5));
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  initial begin
    rn = 0; dn = 0; req = 0; rn5 = 0; dn5 = 0; req5 = 0;
    tick(); tick();
    chk("rst_grant", 32'(g), 0);
    chk("rst_valid", 32'(gv), 0);
    chk("rst_id", 32'(gid), 0);
    chk("rst_to", 32'(te), 0);
    rn = 1;
    req = 4'b0100; tick();
    chk("t1_grant", 32'(g), 32'h4);
    chk("t1_id", 32'(gid), 2);
    chk("t1_valid", 32'(gv), 1);
    dn = 1; tick(); dn = 0; req = 0;
    chk("t1_rel", 32'(g), 0);
    chk("t1_relv", 32'(gv), 0);
    chk("t1_id_hold", 32'(gid), 2);
    tick();
    rn = 0; tick(); rn = 1;
    req = 4'b1111; tick();
    for (int k = 0; k < 6; k++) begin
      chk($sformatf("t2_grant%0d", k), 32'(g), 32'(1 << (k % 4)));
      chk($sformatf("t2_id%0d", k), 32'(gid), 32'(k % 4));
      tick(); tick();
      chk($sformatf("t2_held%0d", k), 32'(g), 32'(1 << (k % 4)));
      dn = 1; tick(); dn = 0;
      chk($sformatf("t2_drop%0d", k), 32'(g), 0);
      tick();
      chk($sformatf("t2_idle%0d", k), 32'(g), 0);
      tick();
    end
    req = 0; dn = 1; tick(); dn = 0; tick(); tick();
    req = 4'b0010; tick();
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("t3_hold%0d", i), 32'(g), 32'h2);
      chk($sformatf("t3_to%0d", i), 32'(te), 0);
      tick();
    end
    chk("t3_drop", 32'(g), 0);
    chk("t3_to_pulse", 32'(te), 1);
    req = 4'b0110; tick();
    chk("t3_to_clear", 32'(te), 0);
    tick();
    chk("t3_ptr_grant", 32'(g), 32'h4);
    dn = 1; tick(); dn = 0; req = 0; tick();
    req = 4'b1000; tick();
    chk("t4_grant", 32'(g), 32'h8);
    for (int i = 0; i < 7; i++) tick();
    chk("t4_still", 32'(g), 32'h8);
    dn = 1; tick(); dn = 0; req = 0;
    chk("t4_drop", 32'(g), 0);
    chk("t4_no_to", 32'(te), 0);
    tick();
    req = 4'b0010; tick();
    chk("t5_grant", 32'(g), 32'h2);
    tick();
    rn = 0; dn = 1; req = 4'b1001; tick();
    chk("t5_rst_grant", 32'(g), 0);
    chk("t5_rst_valid", 32'(gv), 0);
    chk("t5_rst_id", 32'(gid), 0);
    rn = 1; dn = 0; tick();
    chk("t5_winner", 32'(g), 32'h1);
    chk("t5_winner_id", 32'(gid), 0);
    rn5 = 1; req5 = 5'b00001; tick();
    chk("t6_first", 32'(g5), 32'h1);
    dn5 = 1; tick(); dn5 = 0; tick();
    req5 = 5'b10001; tick();
    chk("t6_id4", 32'(gid5), 4);
    chk("t6_grant4", 32'(g5), 32'h10);
    dn5 = 1; tick(); dn5 = 0; tick(); tick();
    chk("t6_id0", 32'(gid5), 0);
    chk("t6_grant0", 32'(g5), 32'h1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
